// File: rtl/lsu_stage_pkg.sv
// lsu_stage_pkg: shared opcode enums and LSU FSM state encodings for the RV32I pipeline.
package lsu_stage_pkg;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
  } alu_op_e;
  typedef enum logic [3:0] {
    MEM_NONE, LB, LH, LW, LBU, LHU, SB, SH, SW
  } mem_op_e;
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] REQ      = 2'd1;
  localparam logic [1:0] WAIT_RSP = 2'd2;
endpackage

// File: rtl/lsu_stage_if.sv
// lsu_stage_if: req/gnt/rvalid data-memory port between the LSU and data memory.
interface lsu_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [3:0]            be;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;
  modport master(output req, we, addr, be, wdata, input gnt, rvalid, rdata);
  modport slave(input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/lsu_load_align.sv
// lsu_load_align: selects the addressed byte/halfword lane of a load word and sign/zero-extends it.
module lsu_load_align
  import lsu_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            addr_lo,
  input  mem_op_e               op,
  output logic [DATA_WIDTH-1:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b    = rdata[{addr_lo, 3'b000} +: 8];
    h    = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    data = op == LB  ? {{(DATA_WIDTH-8){b[7]}}, b} :
           op == LBU ? {{(DATA_WIDTH-8){1'b0}}, b} :
           op == LH  ? {{(DATA_WIDTH-16){h[15]}}, h} :
           op == LHU ? {{(DATA_WIDTH-16){1'b0}}, h} : rdata;
  end
endmodule

// File: rtl/lsu_stage.sv
// lsu_stage: RV32I memory stage driving a req/gnt/rvalid data port and registering the WB result.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses instead of issuing them.
module lsu_stage
  import lsu_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  input  mem_op_e               ex_mem_op,
  input  logic [DATA_WIDTH-1:0] ex_alu_result,
  input  logic [DATA_WIDTH-1:0] ex_store_data,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_wb_en,
  input  logic                  flush,
  output logic                  stall,
  lsu_stage_if.master           dmem,
  output logic                  wb_valid,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  wb_en,
  output logic                  misalign
);
  logic [1:0]            state, a_q;
  mem_op_e               op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_n, load_data;
  logic [3:0]            be_q, be_n;
  logic [REG_ADDR_W-1:0] rd_q;
  logic                  we_q, wen_q, kill_q, mis, is_b, is_h, is_st;
  always_comb begin
    is_b    = ex_mem_op inside {LB, LBU, SB};
    is_h    = ex_mem_op inside {LH, LHU, SH};
    is_st   = ex_mem_op inside {SB, SH, SW};
    be_n    = is_b ? 4'b0001 << ex_alu_result[1:0] : is_h ? (ex_alu_result[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata_n = is_b ? {4{ex_store_data[7:0]}} : is_h ? {2{ex_store_data[15:0]}} : ex_store_data;
  end
`ifdef LSU_MISALIGN_TRAP_EN
  assign mis = (is_h && ex_alu_result[0]) || (ex_mem_op inside {LW, SW} && ex_alu_result[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif
  assign stall      = state != IDLE;
  assign dmem.req   = state == REQ;
  assign dmem.we    = we_q;
  assign dmem.addr  = addr_q;
  assign dmem.be    = dmem.req ? be_q : 4'b0000;
  assign dmem.wdata = wdata_q;
  lsu_load_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .rdata  (dmem.rdata),
    .addr_lo(a_q),
    .op     (op_q),
    .data   (load_data)
  );
  // A flush seen while the bus is busy is remembered in kill_q so the result is dropped at completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_q     <= MEM_NONE;
      a_q      <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      wdata_q  <= '0;
      rd_q     <= '0;
      wen_q    <= 1'b0;
      kill_q   <= 1'b0;
      wb_valid <= 1'b0;
      wb_data  <= '0;
      wb_rd    <= '0;
      wb_en    <= 1'b0;
      misalign <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      case (state)
        IDLE: if (ex_valid && !flush) begin
          if (ex_mem_op == MEM_NONE || mis) begin
            wb_valid <= 1'b1;
            wb_data  <= ex_alu_result;
            wb_rd    <= ex_rd;
            wb_en    <= ex_wb_en && !mis;
            misalign <= mis;
          end else begin
            state   <= REQ;
            op_q    <= ex_mem_op;
            a_q     <= ex_alu_result[1:0];
            addr_q  <= {ex_alu_result[ADDR_WIDTH-1:2], 2'b00};
            we_q    <= is_st;
            be_q    <= be_n;
            wdata_q <= wdata_n;
            rd_q    <= ex_rd;
            wen_q   <= ex_wb_en;
            kill_q  <= 1'b0;
          end
        end
        REQ: begin
          kill_q <= kill_q || flush;
          if (dmem.gnt && we_q) begin
            state    <= IDLE;
            wb_valid <= !(kill_q || flush);
            wb_rd    <= rd_q;
            wb_en    <= 1'b0;
            misalign <= 1'b0;
          end else if (dmem.gnt) state <= WAIT_RSP;
        end
        WAIT_RSP: begin
          kill_q <= kill_q || flush;
          if (dmem.rvalid) begin
            state    <= IDLE;
            wb_valid <= !(kill_q || flush);
            wb_data  <= load_data;
            wb_rd    <= rd_q;
            wb_en    <= wen_q;
            misalign <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_stage.sv
// tb_lsu_stage: directed self-checking bench for lsu_stage (honours LSU_MISALIGN_TRAP_EN).
module tb_lsu_stage;
  import lsu_stage_pkg::*;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  mem_op_e     ex_mem_op = MEM_NONE;
  logic [31:0] ex_alu_result = '0;
  logic [31:0] ex_store_data = '0;
  logic [4:0]  ex_rd = '0;
  logic        ex_wb_en = 1'b0;
  logic        flush = 1'b0;
  logic        stall, wb_valid, wb_en, misalign;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  int          total = 0;
  int          bad = 0;
  lsu_stage_if bus();
  lsu_stage dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_mem_op(ex_mem_op),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_wb_en(ex_wb_en), .flush(flush), .stall(stall), .dmem(bus),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .wb_en(wb_en), .misalign(misalign)
  );
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input mem_op_e op, input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd);
    ex_valid = 1'b1; ex_mem_op = op; ex_alu_result = a; ex_store_data = sd; ex_rd = rd; ex_wb_en = 1'b1;
  endtask
  task automatic do_load(input mem_op_e op, input logic [31:0] a, input logic [31:0] rdata,
                         output logic v, output logic [31:0] d, output logic [31:0] ba);
    issue(op, a, 32'h0, 5'd7);
    step;
    ex_valid = 1'b0;
    ba = bus.addr;
    bus.gnt = 1'b1;
    step;
    bus.gnt = 1'b0;
    step;
    bus.rvalid = 1'b1; bus.rdata = rdata;
    step;
    bus.rvalid = 1'b0;
    v = wb_valid; d = wb_data;
  endtask
  task automatic test_reset;
    #3;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got %b want 0", stall); end
    total++; if (bus.req !== 1'b0 || bus.we !== 1'b0 || bus.be !== 4'h0) begin bad++; $display("FAIL reset_bus got req=%b we=%b be=%h want 0", bus.req, bus.we, bus.be); end
    total++; if (bus.addr !== 32'h0 || bus.wdata !== 32'h0) begin bad++; $display("FAIL reset_addr got %h/%h want 0", bus.addr, bus.wdata); end
    total++; if ({wb_valid, wb_en, misalign} !== 3'b000 || wb_data !== 32'h0 || wb_rd !== 5'd0) begin bad++; $display("FAIL reset_wb got v=%b en=%b m=%b d=%h rd=%0d want 0", wb_valid, wb_en, misalign, wb_data, wb_rd); end
    step;
    rst_n = 1'b1;
    step;
  endtask
  task automatic test_none;
    issue(MEM_NONE, 32'h1234_5678, 32'h0, 5'd5);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL none_stall0 got %b want 0", stall); end
    step;
    ex_valid = 1'b0;
    total++; if (wb_valid !== 1'b1 || wb_data !== 32'h1234_5678) begin bad++; $display("FAIL none_wb got v=%b d=%h want 1/12345678", wb_valid, wb_data); end
    total++; if (wb_rd !== 5'd5 || wb_en !== 1'b1 || stall !== 1'b0 || bus.req !== 1'b0) begin bad++; $display("FAIL none_misc got rd=%0d en=%b stall=%b req=%b want 5/1/0/0", wb_rd, wb_en, stall, bus.req); end
    step;
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL none_pulse got %b want 0", wb_valid); end
    issue(MEM_NONE, 32'hCAFE_0001, 32'h0, 5'd9);
    flush = 1'b1;
    step;
    ex_valid = 1'b0; flush = 1'b0;
    total++; if (wb_valid !== 1'b0 || wb_data !== 32'h1234_5678) begin bad++; $display("FAIL none_flush got v=%b d=%h want 0/12345678", wb_valid, wb_data); end
  endtask
  task automatic test_store;
    issue(SB, 32'h0000_0103, 32'h0000_00AB, 5'd3);
    step;
    ex_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total++; if (bus.req !== 1'b1 || bus.we !== 1'b1 || stall !== 1'b1) begin bad++; $display("FAIL sb_req%0d got req=%b we=%b stall=%b want 1", i, bus.req, bus.we, stall); end
      total++; if (bus.addr !== 32'h100 || bus.be !== 4'b1000 || bus.wdata !== 32'hABAB_ABAB) begin bad++; $display("FAIL sb_bus%0d got a=%h be=%b wd=%h want 100/1000/abababab", i, bus.addr, bus.be, bus.wdata); end
      step;
    end
    bus.gnt = 1'b1;
    total++; if (bus.req !== 1'b1 || stall !== 1'b1) begin bad++; $display("FAIL sb_gnt got req=%b stall=%b want 1", bus.req, stall); end
    step;
    bus.gnt = 1'b0;
    total++; if (wb_valid !== 1'b1 || wb_en !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL sb_done got v=%b en=%b stall=%b want 1/0/0", wb_valid, wb_en, stall); end
    total++; if (bus.req !== 1'b0 || bus.be !== 4'b0000) begin bad++; $display("FAIL sb_idle got req=%b be=%b want 0/0000", bus.req, bus.be); end
    issue(SH, 32'h0000_0206, 32'h1234_BEEF, 5'd3);
    step;
    ex_valid = 1'b0;
    total++; if (bus.addr !== 32'h204 || bus.be !== 4'b1100 || bus.wdata !== 32'hBEEF_BEEF) begin bad++; $display("FAIL sh_bus got a=%h be=%b wd=%h want 204/1100/beefbeef", bus.addr, bus.be, bus.wdata); end
    bus.gnt = 1'b1;
    step;
    bus.gnt = 1'b0;
    issue(SW, 32'h0000_0308, 32'h8765_4321, 5'd3);
    step;
    ex_valid = 1'b0;
    total++; if (bus.addr !== 32'h308 || bus.be !== 4'b1111 || bus.wdata !== 32'h8765_4321) begin bad++; $display("FAIL sw_bus got a=%h be=%b wd=%h want 308/1111/87654321", bus.addr, bus.be, bus.wdata); end
    bus.gnt = 1'b1;
    step;
    bus.gnt = 1'b0;
    step;
  endtask
  task automatic test_loads;
    logic v;
    logic [31:0] d, ba;
    do_load(LB, 32'h102, 32'h0080_0000, v, d, ba);
    total++; if (v !== 1'b1 || d !== 32'hFFFF_FF80 || ba !== 32'h100) begin bad++; $display("FAIL lb got v=%b d=%h a=%h want 1/ffffff80/100", v, d, ba); end
    total++; if (wb_rd !== 5'd7 || wb_en !== 1'b1) begin bad++; $display("FAIL lb_rd got rd=%0d en=%b want 7/1", wb_rd, wb_en); end
    do_load(LBU, 32'h102, 32'h0080_0000, v, d, ba);
    total++; if (v !== 1'b1 || d !== 32'h0000_0080) begin bad++; $display("FAIL lbu got v=%b d=%h want 1/00000080", v, d); end
    do_load(LH, 32'h102, 32'h8001_0000, v, d, ba);
    total++; if (v !== 1'b1 || d !== 32'hFFFF_8001) begin bad++; $display("FAIL lh got v=%b d=%h want 1/ffff8001", v, d); end
    do_load(LHU, 32'h100, 32'h8001_8002, v, d, ba);
    total++; if (v !== 1'b1 || d !== 32'h0000_8002) begin bad++; $display("FAIL lhu got v=%b d=%h want 1/00008002", v, d); end
    do_load(LB, 32'h101, 32'h0000_7F00, v, d, ba);
    total++; if (v !== 1'b1 || d !== 32'h0000_007F) begin bad++; $display("FAIL lb1 got v=%b d=%h want 1/0000007f", v, d); end
    do_load(LW, 32'h104, 32'hDEAD_BEEF, v, d, ba);
    total++; if (v !== 1'b1 || d !== 32'hDEAD_BEEF || ba !== 32'h104) begin bad++; $display("FAIL lw got v=%b d=%h a=%h want 1/deadbeef/104", v, d, ba); end
    step;
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL lw_pulse got %b want 0", wb_valid); end
  endtask
  task automatic test_flush;
    issue(LW, 32'h200, 32'h0, 5'd4);
    step;
    ex_valid = 1'b0;
    bus.gnt = 1'b1;
    step;
    bus.gnt = 1'b0;
    flush = 1'b1;
    total++; if (stall !== 1'b1 || bus.req !== 1'b0) begin bad++; $display("FAIL flush_wait got stall=%b req=%b want 1/0", stall, bus.req); end
    step;
    flush = 1'b0;
    step;
    step;
    bus.rvalid = 1'b1; bus.rdata = 32'h5555_AAAA;
    step;
    bus.rvalid = 1'b0;
    total++; if (wb_valid !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL flush_done got v=%b stall=%b want 0/0", wb_valid, stall); end
    step;
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL flush_after got %b want 0", wb_valid); end
  endtask
  task automatic test_reset_mid;
    issue(SW, 32'h400, 32'h1111_2222, 5'd2);
    step;
    ex_valid = 1'b0;
    total++; if (bus.req !== 1'b1) begin bad++; $display("FAIL rstmid_req got %b want 1", bus.req); end
    rst_n = 1'b0;
    #1;
    total++; if (bus.req !== 1'b0 || stall !== 1'b0 || bus.be !== 4'h0) begin bad++; $display("FAIL rstmid_drop got req=%b stall=%b be=%b want 0", bus.req, stall, bus.be); end
    step;
    rst_n = 1'b1;
    step;
    issue(MEM_NONE, 32'h0BAD_F00D, 32'h0, 5'd11);
    step;
    ex_valid = 1'b0;
    total++; if (wb_valid !== 1'b1 || wb_data !== 32'h0BAD_F00D || wb_rd !== 5'd11) begin bad++; $display("FAIL rstmid_none got v=%b d=%h rd=%0d want 1/0badf00d/11", wb_valid, wb_data, wb_rd); end
    step;
  endtask
  task automatic test_misalign;
    issue(LW, 32'h101, 32'h0, 5'd6);
    step;
    ex_valid = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    total++; if (bus.req !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL mis_noreq got req=%b stall=%b want 0/0", bus.req, stall); end
    total++; if (wb_valid !== 1'b1 || misalign !== 1'b1 || wb_en !== 1'b0 || wb_data !== 32'h101) begin bad++; $display("FAIL mis_trap got v=%b m=%b en=%b d=%h want 1/1/0/101", wb_valid, misalign, wb_en, wb_data); end
    step;
`else
    total++; if (bus.req !== 1'b1 || bus.addr !== 32'h100 || bus.be !== 4'b1111) begin bad++; $display("FAIL mis_issue got req=%b a=%h be=%b want 1/100/1111", bus.req, bus.addr, bus.be); end
    bus.gnt = 1'b1;
    step;
    bus.gnt = 1'b0;
    bus.rvalid = 1'b1; bus.rdata = 32'h1122_3344;
    step;
    bus.rvalid = 1'b0;
    total++; if (wb_valid !== 1'b1 || wb_data !== 32'h1122_3344 || misalign !== 1'b0) begin bad++; $display("FAIL mis_load got v=%b d=%h m=%b want 1/11223344/0", wb_valid, wb_data, misalign); end
`endif
  endtask
  initial begin
    bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
    test_reset;
    test_none;
    test_store;
    test_loads;
    test_flush;
    test_reset_mid;
    test_misalign;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
